// File: rtl/mlt_pkg.sv
// Shared definitions for the multicycle RV32I sequencer: opcodes, state encoding,
// datapath mux-select encodings.
package mlt_pkg;

    localparam int unsigned WAIT_CNT_W = 8;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_LUI    = 4'd4,
        S_AUIPC  = 4'd5,
        S_ALUWB  = 4'd6,
        S_MEMADR = 4'd7,
        S_MEMRD  = 4'd8,
        S_MEMWB  = 4'd9,
        S_MEMWR  = 4'd10,
        S_BRANCH = 4'd11,
        S_JAL    = 4'd12,
        S_JALR   = 4'd13,
        S_ERR    = 4'd15
    } state_e;

    localparam logic [1:0] PC_PLUS4   = 2'd0;
    localparam logic [1:0] PC_TARGET  = 2'd1;
    localparam logic [1:0] PC_JALR    = 2'd2;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;

    localparam logic [1:0] RES_ALU    = 2'd0;
    localparam logic [1:0] RES_LOAD   = 2'd1;
    localparam logic [1:0] RES_PC4    = 2'd2;

    function automatic logic is_wait_state(state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mlt_wait_timer.sv
// Memory-ack wait counter; flags the last allowed wait cycle so the sequencer can bail out.
module mlt_wait_timer
    import mlt_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    logic [WAIT_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // The cycle in which the count would reach MEM_TIMEOUT is the last one allowed.
    assign timeout = en && (cnt_q == LAST_WAIT);

endmodule

// File: rtl/mlt_cycle_ctrl.sv
// Main sequencer for the multicycle RV32I datapath: FETCH/DECODE/EXEC/MEM/WB stepping,
// datapath enables/selects and the MREQ/WRITE handshake with active-low acks.
module mlt_cycle_ctrl
    import mlt_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       br_taken,
    input  logic       ACKI_n,
    input  logic       ACKD_n,
    output logic       ir_write,
    output logic       pc_enable,
    output logic [1:0] pc_src,
    output logic       adr_src,
    output logic [1:0] alu_srca,
    output logic [1:0] alu_srcb,
    output logic [1:0] result_src,
    output logic       reg_write,
    output logic       mreq,
    output logic       write,
    output logic       ill_inst,
    output logic       bus_err,
    output logic [3:0] state
);

    state_e state_q, state_d;
    logic   wait_en, wait_clr, timeout;
    logic   ack_n_sel;

    assign ack_n_sel = (state_q == S_FETCH) ? ACKI_n : ACKD_n;
    assign wait_en   = is_wait_state(state_q) && ack_n_sel;
    assign wait_clr  = (state_d != state_q);

    mlt_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (wait_clr),
        .en     (wait_en),
        .timeout(timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (!ACKI_n) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: state_d = S_ALUWB;
            S_MEMADR: state_d = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (!ACKD_n) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_MEMWR: begin
                if (!ACKD_n) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            S_ALUWB, S_MEMWB, S_BRANCH, S_JAL, S_JALR: state_d = S_FETCH;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_FETCH;
        endcase
    end

    // Held in reset, everything is quiet even though the state register sits at S_FETCH.
    always_comb begin
        ir_write   = 1'b0;
        pc_enable  = 1'b0;
        pc_src     = PC_PLUS4;
        adr_src    = 1'b0;
        alu_srca   = SRCA_PC;
        alu_srcb   = SRCB_RS2;
        result_src = RES_ALU;
        reg_write  = 1'b0;
        mreq       = 1'b0;
        write      = 1'b0;
        ill_inst   = 1'b0;
        bus_err    = 1'b0;
        if (rst) begin
            unique case (state_q)
                S_FETCH: begin
                    mreq      = 1'b1;
                    ir_write  = !ACKI_n;
                    pc_enable = !ACKI_n;
                end
                S_DECODE: begin
                    alu_srca = SRCA_OLDPC;
                    alu_srcb = SRCB_IMM;
                    ill_inst = !(opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                                OP_JAL, OP_JALR, OP_LUI, OP_AUIPC});
                end
                S_EXEC_R: alu_srca = SRCA_RS1;
                S_EXEC_I, S_MEMADR: begin
                    alu_srca = SRCA_RS1;
                    alu_srcb = SRCB_IMM;
                end
                S_LUI: begin
                    alu_srca = SRCA_ZERO;
                    alu_srcb = SRCB_IMM;
                end
                S_AUIPC: begin
                    alu_srca = SRCA_OLDPC;
                    alu_srcb = SRCB_IMM;
                end
                S_ALUWB: reg_write = 1'b1;
                S_MEMRD: begin
                    mreq    = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = RES_LOAD;
                end
                S_MEMWR: begin
                    mreq    = 1'b1;
                    write   = 1'b1;
                    adr_src = 1'b1;
                end
                S_BRANCH: begin
                    pc_src    = PC_TARGET;
                    pc_enable = br_taken;
                end
                S_JAL: begin
                    pc_src     = PC_TARGET;
                    pc_enable  = 1'b1;
                    reg_write  = 1'b1;
                    result_src = RES_PC4;
                end
                S_JALR: begin
                    alu_srca   = SRCA_RS1;
                    alu_srcb   = SRCB_IMM;
                    pc_src     = PC_JALR;
                    pc_enable  = 1'b1;
                    reg_write  = 1'b1;
                    result_src = RES_PC4;
                end
                S_ERR:   bus_err = 1'b1;
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mlt_cycle_ctrl.sv
// Directed self-checking bench for mlt_cycle_ctrl: per-cycle state/strobe expectations.
module tb_mlt_cycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       br_taken;
    logic       ACKI_n;
    logic       ACKD_n;
    logic       ir_write, pc_enable, adr_src, reg_write, mreq, write, ill_inst, bus_err;
    logic [1:0] pc_src, alu_srca, alu_srcb, result_src;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mlt_cycle_ctrl #(
        .MEM_TIMEOUT(15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .br_taken  (br_taken),
        .ACKI_n    (ACKI_n),
        .ACKD_n    (ACKD_n),
        .ir_write  (ir_write),
        .pc_enable (pc_enable),
        .pc_src    (pc_src),
        .adr_src   (adr_src),
        .alu_srca  (alu_srca),
        .alu_srcb  (alu_srcb),
        .result_src(result_src),
        .reg_write (reg_write),
        .mreq      (mreq),
        .write     (write),
        .ill_inst  (ill_inst),
        .bus_err   (bus_err),
        .state     (state)
    );

    // Each cycle: inputs set at posedge+1, outputs checked at posedge+2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; ACKI_n = 1'b1; ACKD_n = 1'b1; opcode = 7'h00; br_taken = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL reset_mreq got %b want 0", mreq); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err got %b want 0", bus_err); end
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write got %b want 0", reg_write); end
        rst = 1'b1;
        tick();
        #1;
        checks++; if (mreq !== 1'b1) begin errors++; $display("FAIL first_fetch_mreq got %b want 1", mreq); end
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL first_fetch_state got %0d want 0", state); end
        tick();
    endtask

    task automatic test_add();
        int st[5] = '{0, 1, 2, 6, 0};
        int rw[5] = '{0, 0, 0, 1, 0};
        opcode = 7'h33;
        for (int i = 0; i < 5; i++) begin
            ACKI_n = (i == 0) ? 1'b0 : 1'b1;
            #1;
            checks++; if (state !== 4'(st[i])) begin errors++; $display("FAIL add_state[%0d] got %0d want %0d", i, state, st[i]); end
            checks++; if (reg_write !== 1'(rw[i])) begin errors++; $display("FAIL add_reg_write[%0d] got %b want %0d", i, reg_write, rw[i]); end
            if (i == 0) begin
                checks++; if (ir_write !== 1'b1) begin errors++; $display("FAIL add_ir_write got %b want 1", ir_write); end
                checks++; if (pc_enable !== 1'b1) begin errors++; $display("FAIL add_pc_enable got %b want 1", pc_enable); end
            end
            if (i == 1) begin
                checks++; if (alu_srca !== 2'd1 || alu_srcb !== 2'd1) begin errors++; $display("FAIL decode_srcs got %0d/%0d want 1/1", alu_srca, alu_srcb); end
            end
            tick();
        end
    endtask

    task automatic test_load();
        int st[9]   = '{0, 1, 7, 8, 8, 8, 8, 9, 0};
        int mq[9]   = '{1, 0, 0, 1, 1, 1, 1, 0, 1};
        int rw[9]   = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        int acki[9] = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
        int ackd[9] = '{0, 0, 0, 1, 1, 1, 0, 1, 1};
        opcode = 7'h03;
        for (int i = 0; i < 9; i++) begin
            ACKI_n = 1'(acki[i]);
            ACKD_n = 1'(ackd[i]);
            #1;
            checks++; if (state !== 4'(st[i])) begin errors++; $display("FAIL lw_state[%0d] got %0d want %0d", i, state, st[i]); end
            checks++; if (mreq !== 1'(mq[i])) begin errors++; $display("FAIL lw_mreq[%0d] got %b want %0d", i, mreq, mq[i]); end
            checks++; if (write !== 1'b0) begin errors++; $display("FAIL lw_write[%0d] got %b want 0", i, write); end
            checks++; if (reg_write !== 1'(rw[i])) begin errors++; $display("FAIL lw_reg_write[%0d] got %b want %0d", i, reg_write, rw[i]); end
            if (st[i] == 9) begin
                checks++; if (result_src !== 2'd1) begin errors++; $display("FAIL lw_result_src got %0d want 1", result_src); end
            end
            tick();
        end
        ACKD_n = 1'b1;
    endtask

    task automatic test_ack_at_timeout();
        opcode = 7'h03;
        for (int i = 0; i < 3; i++) begin
            ACKI_n = (i == 0) ? 1'b0 : 1'b1;
            tick();
        end
        for (int k = 0; k < 15; k++) begin
            ACKD_n = (k == 14) ? 1'b0 : 1'b1;
            #1;
            checks++; if (state !== 4'd8) begin errors++; $display("FAIL tmo_wait_state[%0d] got %0d want 8", k, state); end
            tick();
        end
        ACKD_n = 1'b1;
        #1;
        checks++; if (state !== 4'd9) begin errors++; $display("FAIL tmo_ack_wins got %0d want 9", state); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL tmo_bus_err got %b want 0", bus_err); end
        tick();
    endtask

    task automatic test_branch();
        int st[4] = '{0, 1, 11, 0};
        opcode = 7'h63;
        for (int b = 1; b >= 0; b--) begin
            br_taken = 1'(b);
            for (int i = 0; i < 4; i++) begin
                ACKI_n = (i == 0) ? 1'b0 : 1'b1;
                #1;
                checks++; if (state !== 4'(st[i])) begin errors++; $display("FAIL beq%0d_state[%0d] got %0d want %0d", b, i, state, st[i]); end
                if (i == 2) begin
                    checks++; if (pc_enable !== 1'(b)) begin errors++; $display("FAIL beq%0d_pc_enable got %b want %0d", b, pc_enable, b); end
                    checks++; if (pc_src !== 2'd1) begin errors++; $display("FAIL beq%0d_pc_src got %0d want 1", b, pc_src); end
                end
                tick();
            end
        end
        br_taken = 1'b0;
    endtask

    task automatic test_jumps();
        logic [6:0] ops[2] = '{7'h6F, 7'h67};
        int         st[2]  = '{12, 13};
        int         ps[2]  = '{1, 2};
        for (int j = 0; j < 2; j++) begin
            opcode = ops[j];
            ACKI_n = 1'b0;
            tick();
            ACKI_n = 1'b1;
            tick();
            #1;
            checks++; if (state !== 4'(st[j])) begin errors++; $display("FAIL jump%0d_state got %0d want %0d", j, state, st[j]); end
            checks++; if (pc_src !== 2'(ps[j])) begin errors++; $display("FAIL jump%0d_pc_src got %0d want %0d", j, pc_src, ps[j]); end
            checks++; if (pc_enable !== 1'b1 || reg_write !== 1'b1) begin errors++; $display("FAIL jump%0d_strobes got %b%b want 11", j, pc_enable, reg_write); end
            checks++; if (result_src !== 2'd2) begin errors++; $display("FAIL jump%0d_result_src got %0d want 2", j, result_src); end
            tick();
            #1;
            checks++; if (state !== 4'd0) begin errors++; $display("FAIL jump%0d_return got %0d want 0", j, state); end
            tick();
        end
    endtask

    task automatic test_illegal();
        int st[3] = '{0, 1, 0};
        int il[3] = '{0, 1, 0};
        opcode = 7'h7F;
        for (int i = 0; i < 3; i++) begin
            ACKI_n = (i == 0) ? 1'b0 : 1'b1;
            #1;
            checks++; if (state !== 4'(st[i])) begin errors++; $display("FAIL ill_state[%0d] got %0d want %0d", i, state, st[i]); end
            checks++; if (ill_inst !== 1'(il[i])) begin errors++; $display("FAIL ill_inst[%0d] got %b want %0d", i, ill_inst, il[i]); end
            checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL ill_reg_write[%0d] got %b want 0", i, reg_write); end
            if (i == 2) begin
                checks++; if (mreq !== 1'b1) begin errors++; $display("FAIL ill_next_fetch got %b want 1", mreq); end
            end
            tick();
        end
    endtask

    task automatic test_store_timeout();
        opcode = 7'h23;
        ACKD_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ACKI_n = (i == 0) ? 1'b0 : 1'b1;
            tick();
        end
        for (int k = 0; k < 15; k++) begin
            #1;
            checks++; if (state !== 4'd10 || mreq !== 1'b1 || write !== 1'b1) begin
                errors++; $display("FAIL sw_wait[%0d] got st=%0d mreq=%b write=%b want 10/1/1", k, state, mreq, write);
            end
            tick();
        end
        ACKI_n = 1'b0;
        ACKD_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (state !== 4'd15) begin errors++; $display("FAIL err_state[%0d] got %0d want 15", k, state); end
            checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL err_bus_err[%0d] got %b want 1", k, bus_err); end
            checks++; if (mreq !== 1'b0 || write !== 1'b0) begin errors++; $display("FAIL err_strobes[%0d] got %b%b want 00", k, mreq, write); end
            tick();
        end
        ACKI_n = 1'b1;
        ACKD_n = 1'b1;
    endtask

    task automatic test_reset_midwait();
        rst = 1'b0;
        #1;
        checks++; if (state !== 4'd0 || bus_err !== 1'b0) begin errors++; $display("FAIL err_reset got st=%0d bus_err=%b want 0/0", state, bus_err); end
        tick();
        rst = 1'b1;
        tick();
        opcode = 7'h03;
        for (int i = 0; i < 5; i++) begin
            ACKI_n = (i == 0) ? 1'b0 : 1'b1;
            tick();
        end
        #1;
        checks++; if (state !== 4'd8) begin errors++; $display("FAIL midwait_pre got %0d want 8", state); end
        rst = 1'b0;
        #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL midwait_state got %0d want 0", state); end
        checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL midwait_mreq got %b want 0", mreq); end
        tick();
        rst = 1'b1;
        tick();
        #1;
        checks++; if (mreq !== 1'b1 || state !== 4'd0) begin errors++; $display("FAIL midwait_refetch got mreq=%b st=%0d want 1/0", mreq, state); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_load();
        test_ack_at_timeout();
        test_branch();
        test_jumps();
        test_illegal();
        test_store_timeout();
        test_reset_midwait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
